// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : funct3 codes, sequencer states and access-legality check.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // Unsigned variants exist only for loads; stores accept b/h/w only.
    function automatic logic access_err(input logic       store,
                                        input logic [2:0] func3,
                                        input logic [1:0] off);
        logic err;
        case (func3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_fmt.sv
// ============================================================================
// Module   : lsu_lane_fmt
// Brief    : Byte-lane merge for sub-word stores and load extract/extend.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    output logic [31:0] wr_word,
    output logic [31:0] ld_val
);

    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;

    always_comb begin
        case (off)
            2'd0:    w_sel_byte = old_word[7:0];
            2'd1:    w_sel_byte = old_word[15:8];
            2'd2:    w_sel_byte = old_word[23:16];
            default: w_sel_byte = old_word[31:24];
        endcase
        w_sel_half = off[1] ? old_word[31:16] : old_word[15:0];

        wr_word = st_data;
        case (func3)
            F3_B: begin
                wr_word = old_word;
                case (off)
                    2'd0:    wr_word[7:0]   = st_data[7:0];
                    2'd1:    wr_word[15:8]  = st_data[7:0];
                    2'd2:    wr_word[23:16] = st_data[7:0];
                    default: wr_word[31:24] = st_data[7:0];
                endcase
            end
            F3_H: begin
                wr_word = old_word;
                if (off[1]) wr_word[31:16] = st_data[15:0];
                else        wr_word[15:0]  = st_data[15:0];
            end
            default: ;
        endcase

        ld_val = old_word;
        case (func3)
            F3_B:    ld_val = {{24{w_sel_byte[7]}}, w_sel_byte};
            F3_BU:   ld_val = {24'd0, w_sel_byte};
            F3_H:    ld_val = {{16{w_sel_half[15]}}, w_sel_half};
            F3_HU:   ld_val = {16'd0, w_sel_half};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_rmw_ctrl.sv
// ============================================================================
// Module   : dmem_rmw_ctrl
// Brief    : MEM-stage sequencer driving a single-port word SRAM (RMW stores).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_rmw_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_func3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    func3_q, func3_d;
    logic [1:0]    off_q, off_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          err_q, err_d;

    logic [31:0]   w_old_word;
    logic [31:0]   w_wr_word;
    logic [31:0]   w_ld_val;
    logic          w_unused_addr;

    assign w_unused_addr = ^req_addr[31:AW+2];

    // Loads extract straight from the SRAM output in WAIT; the merge uses the held word.
    assign w_old_word = (state_q == WAIT) ? mem_rdata : rdata_q;

    lsu_lane_fmt u_lane_fmt (
        .func3    (func3_q),
        .off      (off_q),
        .old_word (w_old_word),
        .st_data  (wdata_q),
        .wr_word  (w_wr_word),
        .ld_val   (w_ld_val)
    );

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        func3_d      = func3_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_rdata_d = resp_rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d      = req_store;
                    func3_d      = req_func3;
                    off_d        = req_addr[1:0];
                    waddr_d      = req_addr[AW+1:2];
                    wdata_d      = req_wdata;
                    rdata_d      = '0;
                    resp_rdata_d = '0;
                    err_d        = access_err(req_store, req_func3, req_addr[1:0]);
                    if (err_d)
                        state_d = RESP;
                    else if (req_store && (req_func3 == F3_W))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:   state_d = WAIT;
            WAIT: begin
                rdata_d = mem_rdata;
                if (store_q) begin
                    state_d = WR;
                end else begin
                    resp_rdata_d = w_ld_val;
                    state_d      = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            func3_q      <= 3'd0;
            off_q        <= 2'd0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_en     = (state_q == RD) || (state_q == WR);
    assign mem_we     = (state_q == WR);
    assign mem_addr   = waddr_q;
    assign mem_wdata  = w_wr_word;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? resp_rdata_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_rmw_ctrl.sv
// ============================================================================
// Module   : tb_dmem_rmw_ctrl
// Brief    : Vector table + response scoreboard against a behavioural SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_rmw_ctrl;
    import lsu_pkg::*;

    localparam int AW = 10;
    localparam int NV = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_func3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural SRAM; the bench preloads words through its own write port.
    logic [31:0]   sram [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_idx = '0;
    logic [31:0]   pre_val = '0;

    always @(posedge clk) begin
        if (pre_we) sram[pre_idx] <= pre_val;
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic pe, input logic [31:0] pv,
                                input logic [31:0] er, input logic ee, input int lat,
                                input int rd, input int wr, input logic [31:0] em);
        vec_t v;
        v.store = st;  v.f3 = f3;  v.addr = a;  v.wdata = wd;
        v.pre_en = pe; v.pre_val = pv;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        v.exp_rd = rd; v.exp_wr = wr; v.exp_mem = em;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        exp_t        got;
        int          lat, rd, wr, waitc;
        bit          seen;
        logic [AW-1:0] widx;
        widx = v.addr[AW+1:2];
        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_store = v.store;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        if (v.pre_en) begin
            pre_we  = 1'b1;
            pre_idx = widx;
            pre_val = v.pre_val;
        end
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        e.rd = v.exp_rd; e.wr = v.exp_wr;
        sb_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the request after acceptance; the DUT must work from its captured copy.
        req_valid = 1'b0;
        pre_we    = 1'b0;
        req_store = 1'($urandom);
        req_func3 = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1; rd = 0; wr = 0; seen = 1'b0;
        while (!seen && lat <= 12) begin
            if (mem_en && !mem_we) rd++;
            if (mem_en && mem_we)  wr++;
            if (resp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout actual=no_response required=response", idx);
            void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d_sb_empty actual=response required=none", idx);
            return;
        end
        got = sb_q.pop_front();
        chk($sformatf("v%0d_latency", idx), lat, got.lat);
        chk($sformatf("v%0d_rdata", idx), resp_rdata, got.rdata);
        chk($sformatf("v%0d_err", idx), {31'd0, resp_err}, {31'd0, got.err});
        chk($sformatf("v%0d_reads", idx), rd, got.rd);
        chk($sformatf("v%0d_writes", idx), wr, got.wr);
        if (v.store && !v.exp_err)
            chk($sformatf("v%0d_mem", idx), sram[widx], v.exp_mem);
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_end", idx), {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        //             st   f3     addr          wdata         pre  preval        rdata         err  L  r  w  mem
        vecs[0]  = mk(1'b0, F3_B,  32'h11,       32'h0,        1'b1, 32'h8899AABB, 32'hFFFFFFAA, 1'b0, 3, 1, 0, 32'h0);
        vecs[1]  = mk(1'b0, F3_BU, 32'h11,       32'h0,        1'b0, 32'h0,        32'h000000AA, 1'b0, 3, 1, 0, 32'h0);
        vecs[2]  = mk(1'b1, F3_B,  32'h12,       32'h55,       1'b1, 32'h8899AABB, 32'h0,        1'b0, 4, 1, 1, 32'h8855AABB);
        vecs[3]  = mk(1'b0, F3_W,  32'h10,       32'h0,        1'b0, 32'h0,        32'h8855AABB, 1'b0, 3, 1, 0, 32'h0);
        vecs[4]  = mk(1'b1, F3_H,  32'h12,       32'hCAFE,     1'b1, 32'h8899AABB, 32'h0,        1'b0, 4, 1, 1, 32'hCAFEAABB);
        vecs[5]  = mk(1'b0, F3_H,  32'h12,       32'h0,        1'b0, 32'h0,        32'hFFFFCAFE, 1'b0, 3, 1, 0, 32'h0);
        vecs[6]  = mk(1'b0, F3_HU, 32'h12,       32'h0,        1'b0, 32'h0,        32'h0000CAFE, 1'b0, 3, 1, 0, 32'h0);
        vecs[7]  = mk(1'b1, F3_W,  32'h10,       32'h12345678, 1'b1, 32'h8899AABB, 32'h0,        1'b0, 2, 0, 1, 32'h12345678);
        vecs[8]  = mk(1'b0, F3_W,  32'h12,       32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[9]  = mk(1'b1, F3_H,  32'h13,       32'hFFFF,     1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[10] = mk(1'b0, 3'd3,  32'h10,       32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[11] = mk(1'b0, F3_B,  32'h13,       32'h0,        1'b0, 32'h0,        32'h00000012, 1'b0, 3, 1, 0, 32'h0);
        vecs[12] = mk(1'b0, F3_H,  32'h10,       32'h0,        1'b0, 32'h0,        32'h00005678, 1'b0, 3, 1, 0, 32'h0);
        vecs[13] = mk(1'b1, F3_B,  32'h10,       32'hFFFFFF99, 1'b0, 32'h0,        32'h0,        1'b0, 4, 1, 1, 32'h12345699);
        vecs[14] = mk(1'b1, F3_BU, 32'h10,       32'h11,       1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[15] = mk(1'b1, F3_B,  32'hFFFFF3FD, 32'h5A,       1'b1, 32'hA1B2C3D4, 32'h0,        1'b0, 4, 1, 1, 32'hA1B25AD4);
        vecs[16] = mk(1'b0, F3_BU, 32'hFFFFF3FD, 32'h0,        1'b0, 32'h0,        32'h0000005A, 1'b0, 3, 1, 0, 32'h0);
        vecs[17] = mk(1'b0, F3_HU, 32'h11,       32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);

        rst_n = 1'b0; req_valid = 1'b1; req_store = 1'b1; req_func3 = F3_W;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {25'd0, req_ready, mem_en, mem_we, resp_valid, resp_err, 2'b00},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        chk("reset_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset while an sb sits in WAIT: the write must never happen.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_func3 = F3_B;
        req_addr = 32'h11; req_wdata = 32'h77;
        pre_we = 1'b1; pre_idx = 10'd4; pre_val = 32'h8899AABB;
        @(posedge clk); #1;
        req_valid = 1'b0; pre_we = 1'b0;
        chk("rst_seq_rd", {30'd0, mem_en, mem_we}, 32'd2);
        @(posedge clk); #1;
        chk("rst_seq_wait", {30'd0, mem_en, mem_we}, 32'd0);
        rst_n = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq_outputs",
            {27'd0, req_ready, mem_en, mem_we, resp_valid, resp_err},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (mem_we || mem_en || resp_valid || !req_ready) bad++;
            @(posedge clk); #1;
        end
        chk("rst_seq_quiet", bad, 0);
        chk("rst_seq_mem", sram[4], 32'h8899AABB);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
